// File: rtl/adam_fabric_pause_seq.sv
// adam_fabric_pause_seq: expands one pause request into ordered per-domain req/ack handshakes.
// Optional per-step watchdog enabled by defining ADAM_FABRIC_PAUSE_SEQ_TIMEOUT_EN.
module adam_fabric_pause_seq #(
   parameter int NO_DOMS = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IW = (NO_DOMS > 1) ? $clog2(NO_DOMS) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               pause_req_i,
   output logic               pause_ack_o,
   output logic [NO_DOMS-1:0] dom_req_o,
   input  logic [NO_DOMS-1:0] dom_ack_i,
   output logic               busy_o,
   output logic [IW-1:0]      cur_idx_o,
   output logic               timeout_o
);
   typedef enum logic [1:0] {IDLE, PAUSING, PAUSED, RESUMING} state_e;
   localparam logic [IW-1:0] LAST = IW'(NO_DOMS - 1);
   state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [NO_DOMS-1:0] req_q, req_d, idx_bit;
   logic ack, expire;
   assign idx_bit = NO_DOMS'(1) << idx_q;
   assign ack = |(dom_ack_i & idx_bit);
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      req_d = req_q;
      unique case (state_q)
         IDLE: if (pause_req_i) begin
            state_d = PAUSING;
            idx_d = '0;
            req_d = NO_DOMS'(1);
         end
         PAUSING: if (ack || expire) begin
            if (!pause_req_i) begin
               state_d = RESUMING;
               req_d = req_q & ~idx_bit;
            end else if (idx_q == LAST) state_d = PAUSED;
            else begin
               idx_d = idx_q + IW'(1);
               req_d = req_q | (idx_bit << 1);
            end
         end
         PAUSED: if (!pause_req_i) begin
            state_d = RESUMING;
            req_d = req_q & ~idx_bit;
         end
         RESUMING: if (!ack || expire) begin
            if (idx_q == '0) state_d = IDLE;
            else begin
               idx_d = idx_q - IW'(1);
               req_d = req_q & ~(idx_bit >> 1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q <= '0;
         req_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         req_q <= req_d;
      end
   end
   assign pause_ack_o = state_q == PAUSED;
   assign busy_o = state_q == PAUSING || state_q == RESUMING;
   assign cur_idx_o = idx_q;
   assign dom_req_o = req_q;
`ifdef ADAM_FABRIC_PAUSE_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic to_q, to_d;
   // the expiring cycle is the one whose increment would reach TIMEOUT_CYCLES
   assign expire = busy_o && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      cnt_d = (state_d != state_q || idx_d != idx_q || !busy_o) ? '0 : cnt_q + CW'(1);
      to_d = (state_q == IDLE && state_d == PAUSING) ? 1'b0
           : to_q | (expire && (state_q == PAUSING ? !ack : ack));
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         to_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q <= to_d;
      end
   end
   assign timeout_o = to_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign expire = 1'b0;
   assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_adam_fabric_pause_seq.sv
// tb_adam_fabric_pause_seq: directed and randomized checks against a prefix-count reference model.
module tb_adam_fabric_pause_seq;
   localparam int N = 4;
   localparam int IW = 2;
   localparam int TO = 16;
`ifdef ADAM_FABRIC_PAUSE_SEQ_TIMEOUT_EN
   localparam bit TE = 1'b1;
`else
   localparam bit TE = 1'b0;
`endif
   logic clk_i = 1'b0, rst_ni = 1'b0, pause_req_i = 1'b0;
   logic [N-1:0] dom_ack_i = '0;
   logic pause_ack_o, busy_o, timeout_o;
   logic [N-1:0] dom_req_o;
   logic [IW-1:0] cur_idx_o;
   int tests = 0, fails = 0;
   // model: n = number of domains currently requested, mode 0 idle/1 pausing/2 paused/3 resuming
   int n = 0, mode = 0, w = 0;
   bit to_m = 1'b0, rnd = 1'b0;
   logic [N-1:0] prev_req = '0, stuck = '0, seen = '0;

   always #5 clk_i = ~clk_i;

   adam_fabric_pause_seq #(.NO_DOMS(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pause_req_i(pause_req_i), .pause_ack_o(pause_ack_o),
      .dom_req_o(dom_req_o), .dom_ack_i(dom_ack_i), .busy_o(busy_o), .cur_idx_o(cur_idx_o),
      .timeout_o(timeout_o));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_v();
      logic [N-1:0] m = N'((1 << n) - 1);
      logic [IW-1:0] ix = IW'(mode == 1 ? n - 1 : mode == 3 ? n : mode == 2 ? N - 1 : 0);
      return 32'({mode == 2, mode == 1 || mode == 3, ix, m, to_m});
   endfunction

   function automatic logic [31:0] dut_v();
      return 32'({pause_ack_o, busy_o, cur_idx_o, dom_req_o, timeout_o});
   endfunction

   task automatic model_reset();
      n = 0; mode = 0; w = 0; to_m = 1'b0;
   endtask

   task automatic model_edge();
      logic [N-1:0] ak = dom_ack_i;
      bit pr = pause_req_i;
      int pn = n, pm = mode, i;
      bit ex = TE && (w == TO - 1);
      case (mode)
         0: if (pr) begin mode = 1; n = 1; to_m = 1'b0; end
         1: begin
            i = n - 1;
            if (ak[i] || ex) begin
               if (!ak[i]) to_m = 1'b1;
               if (!pr) begin mode = 3; n--; end
               else if (n == N) mode = 2;
               else n++;
            end
         end
         2: if (!pr) begin mode = 3; n = N - 1; end
         default: begin
            i = n;
            if (!ak[i] || ex) begin
               if (ak[i]) to_m = 1'b1;
               if (n == 0) mode = 0;
               else n--;
            end
         end
      endcase
      w = (mode != pm || n != pn || !(pm == 1 || pm == 3)) ? 0 : w + 1;
   endtask

   task automatic step();
      logic [N-1:0] a;
      @(posedge clk_i);
      model_edge();
      #1;
      check("cycle", dut_v(), exp_v());
      seen |= dom_req_o;
      if (rnd) begin
         a = dom_ack_i;
         for (int i = 0; i < N; i++)
            if (dom_req_o[i] != a[i]) begin
               if ($urandom_range(0, 1) == 1) a[i] = dom_req_o[i];
            end else if (!dom_req_o[i] && $urandom_range(0, 15) == 0) a[i] = 1'b1;
         dom_ack_i = a;
      end else dom_ack_i = prev_req & ~stuck;
      prev_req = dom_req_o;
   endtask

   initial begin
      logic [3:0] t1_req [9] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hf, 4'hf, 4'hf};
      int k;
      #3;
      check("reset_outputs", dut_v(), 32'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step();
      // full pause with acks one cycle behind requests
      pause_req_i = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         check("pause_req_seq", 32'(dom_req_o), 32'(t1_req[c-1]));
         check("pause_ack_time", 32'(pause_ack_o), 32'(c == 9));
      end
      pause_req_i = 1'b0;
      step();
      check("resume_ack_drop", 32'({pause_ack_o, dom_req_o}), 32'h07);
      for (k = 0; k < 20 && busy_o; k++) step();
      check("resume_idle", 32'({busy_o, dom_req_o}), 32'd0);
      // abort while domain 1 withholds its ack
      seen = '0;
      stuck = 4'b0010;
      pause_req_i = 1'b1;
      for (k = 0; k < 10 && cur_idx_o != 2'd1; k++) step();
      check("abort_reach_idx1", 32'(cur_idx_o), 32'd1);
      pause_req_i = 1'b0;
      repeat (5) step();
      check("abort_hold_req1", 32'(dom_req_o), 32'h3);
      stuck = '0;
      for (k = 0; k < 20 && (busy_o || dom_req_o != 0); k++) step();
      check("abort_no_req2", 32'(seen[3:2]), 32'd0);
      check("abort_idle", 32'({busy_o, dom_req_o}), 32'd0);
      // re-request during resume is deferred until idle
      pause_req_i = 1'b1;
      for (k = 0; k < 20 && !pause_ack_o; k++) step();
      check("rr_paused", 32'(pause_ack_o), 32'd1);
      pause_req_i = 1'b0;
      for (k = 0; k < 10 && !(busy_o && cur_idx_o == 2'd2); k++) step();
      check("rr_at_idx2", 32'({busy_o, cur_idx_o}), 32'h6);
      pause_req_i = 1'b1;
      for (k = 0; k < 20 && busy_o; k++) step();
      check("rr_idle", 32'({busy_o, dom_req_o}), 32'd0);
      step();
      check("rr_restart", 32'({busy_o, dom_req_o}), 32'h11);
      pause_req_i = 1'b0;
      for (k = 0; k < 20 && busy_o; k++) step();
      check("rr_back_idle", 32'({busy_o, dom_req_o}), 32'd0);
`ifdef ADAM_FABRIC_PAUSE_SEQ_TIMEOUT_EN
      stuck = 4'b0100;
      pause_req_i = 1'b1;
      k = 0;
      for (int c = 0; c < 60 && cur_idx_o != 2'd3; c++) begin
         step();
         if (cur_idx_o == 2'd2) k++;
      end
      check("to_wait_cycles", 32'(k), 32'(TO));
      check("to_flag", 32'(timeout_o), 32'd1);
      stuck = '0;
      for (k = 0; k < 20 && !pause_ack_o; k++) step();
      pause_req_i = 1'b0;
      for (k = 0; k < 30 && busy_o; k++) step();
      check("to_sticky", 32'({busy_o, timeout_o}), 32'd1);
      pause_req_i = 1'b1;
      step();
      check("to_clear", 32'({busy_o, timeout_o}), 32'h2);
      pause_req_i = 1'b0;
      for (k = 0; k < 20 && busy_o; k++) step();
`endif
      // asynchronous reset while paused
      pause_req_i = 1'b1;
      for (k = 0; k < 20 && !pause_ack_o; k++) step();
      check("rst_paused", 32'(pause_ack_o), 32'd1);
      #3 rst_ni = 1'b0;
      #1;
      check("rst_async", dut_v(), 32'd0);
      model_reset();
      pause_req_i = 1'b0;
      dom_ack_i = '0;
      prev_req = '0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step();
      check("rst_released_idle", 32'({busy_o, cur_idx_o, dom_req_o}), 32'd0);
      // randomized requests, ack latencies and spurious acks
      rnd = 1'b1;
      repeat (1500) begin
         if ($urandom_range(0, 19) == 0) pause_req_i = ~pause_req_i;
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
